// File: rtl/ibex_rvfi_trace_buffer_pkg.sv
// Shared types for the RVFI trace buffer: the stored retirement record,
// the serializer word sequence and the header word layout.
package ibex_rvfi_trace_buffer_pkg;

    localparam logic [3:0]  TraceMagic   = 4'hA;
    localparam int unsigned TraceCntW    = 15;
    localparam logic [2:0]  TraceSeqInit = 3'd0;

    typedef enum logic [1:0] {
        TR_HDR,
        TR_PC,
        TR_INSN,
        TR_WDATA
    } trace_ser_state_e;

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          insn;
        logic [31:0]          rd_wdata;
        logic [4:0]           rd_addr;
        logic                 trap;
        logic                 intr;
        logic [1:0]           mode;
        logic [2:0]           seq;
        logic                 drop;
        logic [TraceCntW-1:0] drop_cnt;
    } trace_rec_t;

    // Header: magic, drop, trap, intr, mode, rd_addr, seq, drop count (MSB to LSB).
    function automatic logic [31:0] trace_hdr_word(input trace_rec_t rec);
        return {TraceMagic, rec.drop, rec.trap, rec.intr, rec.mode,
                rec.rd_addr, rec.seq, rec.drop_cnt};
    endfunction

endpackage

// File: rtl/ibex_trace_rec_fifo.sv
// Synchronous record FIFO with a combinational head; a push into a full FIFO
// is allowed when a pop happens in the same cycle.
module ibex_trace_rec_fifo
    import ibex_rvfi_trace_buffer_pkg::*;
#(
    parameter  int unsigned Depth = 8,
    localparam int unsigned PtrW  = $clog2(Depth)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  trace_rec_t      wdata_i,
    input  logic            pop_i,
    output trace_rec_t      head_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [PtrW:0]   level_o
);

    trace_rec_t        r_mem [Depth];
    logic [PtrW-1:0]   r_wr_ptr;
    logic [PtrW-1:0]   r_rd_ptr;
    logic [PtrW:0]     r_level;
    logic              w_do_pop;
    logic              w_do_push;

    assign empty_o   = (r_level == '0);
    assign full_o    = (r_level == (PtrW+1)'(Depth));
    assign w_do_pop  = pop_i && !empty_o;
    assign w_do_push = push_i && (!full_o || w_do_pop);
    assign head_o    = r_mem[r_rd_ptr];
    assign level_o   = r_level;

    // Depth is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_do_push && !w_do_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_do_pop && !w_do_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

endmodule

// File: rtl/ibex_rvfi_trace_buffer.sv
// Captures one record per retired instruction and drains it as four 32-bit
// words (HDR, PC, INSN, WDATA) over a valid/ready port, counting drops.
module ibex_rvfi_trace_buffer
    import ibex_rvfi_trace_buffer_pkg::*;
#(
    parameter  int unsigned Depth        = 8,
    parameter  int unsigned DropCntWidth = 15,
    localparam int unsigned LevelW       = $clog2(Depth) + 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    rvfi_valid,
    input  logic                    rvfi_trap,
    input  logic                    rvfi_intr,
    input  logic [1:0]              rvfi_mode,
    input  logic [4:0]              rvfi_rd_addr,
    input  logic [31:0]             rvfi_rd_wdata,
    input  logic [31:0]             rvfi_pc_rdata,
    input  logic [31:0]             rvfi_insn,
    output logic                    trace_valid_o,
    input  logic                    trace_ready_i,
    output logic [31:0]             trace_data_o,
    output logic                    trace_last_o,
    output logic [LevelW-1:0]       level_o,
    output logic [DropCntWidth-1:0] drop_cnt_o
);

    trace_ser_state_e        r_state;
    trace_ser_state_e        w_state_next;
    logic [2:0]              r_seq;
    logic [DropCntWidth-1:0] r_drop_cnt;

    trace_rec_t              w_rec;
    trace_rec_t              w_head;
    logic                    w_full;
    logic                    w_empty;
    logic                    w_hs;
    logic                    w_pop;
    logic                    w_capture;
    logic                    w_accept;
    logic                    w_drop;

    assign trace_valid_o = !w_empty;
    assign w_hs          = trace_valid_o && trace_ready_i;
    assign w_pop         = w_hs && (r_state == TR_WDATA);
    assign w_capture     = enable_i && rvfi_valid;
    assign w_accept      = w_capture && (!w_full || w_pop);
    assign w_drop        = w_capture && !w_accept;
    assign drop_cnt_o    = r_drop_cnt;

    always_comb begin
        w_rec          = '0;
        w_rec.pc       = rvfi_pc_rdata;
        w_rec.insn     = rvfi_insn;
        w_rec.rd_wdata = rvfi_rd_wdata;
        w_rec.rd_addr  = rvfi_rd_addr;
        w_rec.trap     = rvfi_trap;
        w_rec.intr     = rvfi_intr;
        w_rec.mode     = rvfi_mode;
        w_rec.seq      = r_seq;
        w_rec.drop     = (r_drop_cnt != '0);
        w_rec.drop_cnt = r_drop_cnt;
    end

    ibex_trace_rec_fifo #(
        .Depth (Depth)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (w_accept),
        .wdata_i (w_rec),
        .pop_i   (w_pop),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .level_o (level_o)
    );

    // The accepting record carries the pending count away, so it clears here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_seq      <= TraceSeqInit;
            r_drop_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_seq      <= r_seq + 1'b1;
                r_drop_cnt <= '0;
            end else if (w_drop && (r_drop_cnt != '1)) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= TR_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_hs) begin
            case (r_state)
                TR_HDR:   w_state_next = TR_PC;
                TR_PC:    w_state_next = TR_INSN;
                TR_INSN:  w_state_next = TR_WDATA;
                TR_WDATA: w_state_next = TR_HDR;
                default:  w_state_next = TR_HDR;
            endcase
        end
    end

    // Words come straight from the head record, so they hold while stalled.
    always_comb begin
        trace_data_o = '0;
        trace_last_o = 1'b0;
        if (!w_empty) begin
            case (r_state)
                TR_HDR:   trace_data_o = trace_hdr_word(w_head);
                TR_PC:    trace_data_o = w_head.pc;
                TR_INSN:  trace_data_o = w_head.insn;
                TR_WDATA: begin
                    trace_data_o = (w_head.rd_addr == 5'd0) ? 32'd0 : w_head.rd_wdata;
                    trace_last_o = 1'b1;
                end
                default:  trace_data_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_rvfi_trace_buffer.sv
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-of-records model of the trace buffer.
module tb_ibex_rvfi_trace_buffer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rv;
    logic        trap;
    logic        intr;
    logic [1:0]  mode;
    logic [4:0]  rd;
    logic [31:0] wdata;
    logic [31:0] pc;
    logic [31:0] insn;
    logic        ready;
    logic        trace_valid_o;
    logic [31:0] trace_data_o;
    logic        trace_last_o;
    logic [3:0]  level_o;
    logic [14:0] drop_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: each queued record is its four words, word k at bits [32k +: 32].
    logic [127:0] m_q[$];
    int           m_idx  = 0;
    int           m_drop = 0;
    int           m_seq  = 0;

    int hs_cnt;
    int rec_cnt;

    always #5 clk = ~clk;

    ibex_rvfi_trace_buffer dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .enable_i      (en),
        .rvfi_valid    (rv),
        .rvfi_trap     (trap),
        .rvfi_intr     (intr),
        .rvfi_mode     (mode),
        .rvfi_rd_addr  (rd),
        .rvfi_rd_wdata (wdata),
        .rvfi_pc_rdata (pc),
        .rvfi_insn     (insn),
        .trace_valid_o (trace_valid_o),
        .trace_ready_i (ready),
        .trace_data_o  (trace_data_o),
        .trace_last_o  (trace_last_o),
        .level_o       (level_o),
        .drop_cnt_o    (drop_cnt_o)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic model_check();
        logic [127:0] rec;
        logic [31:0]  exp_word;
        check_val("valid", trace_valid_o, 32'(m_q.size() != 0));
        check_val("level", level_o, 32'(m_q.size()));
        check_val("drop_cnt", drop_cnt_o, 32'(m_drop));
        if (m_q.size() != 0) begin
            rec      = m_q[0];
            exp_word = rec[m_idx*32 +: 32];
            check_val("data", trace_data_o, exp_word);
            check_val("last", trace_last_o, 32'(m_idx == 3));
        end else begin
            check_val("idle_data", trace_data_o, 32'd0);
            check_val("idle_last", trace_last_o, 32'd0);
        end
    endtask

    task automatic model_step();
        bit           hs;
        bit           pop;
        bit           cap;
        bit           acc;
        logic [31:0]  hdr;
        logic [31:0]  wd;
        int           dflag;
        if (rst) begin
            m_q.delete();
            m_idx  = 0;
            m_drop = 0;
            m_seq  = 0;
            return;
        end
        hs  = (m_q.size() != 0) && ready;
        pop = hs && (m_idx == 3);
        cap = en && rv;
        acc = cap && ((m_q.size() < DEPTH) || pop);
        if (hs) begin
            if (pop) begin
                void'(m_q.pop_front());
                m_idx = 0;
            end else begin
                m_idx++;
            end
        end
        if (acc) begin
            dflag = (m_drop != 0) ? 1 : 0;
            hdr = 32'hA000_0000 + 32'(dflag) * (1 << 27) + 32'(trap) * (1 << 26)
                + 32'(intr) * (1 << 25) + 32'(mode) * (1 << 23) + 32'(rd) * (1 << 18)
                + 32'(m_seq) * (1 << 15) + 32'(m_drop);
            wd  = (rd == 5'd0) ? 32'd0 : wdata;
            m_q.push_back({wd, insn, pc, hdr});
            m_drop = 0;
            m_seq  = (m_seq + 1) % 8;
        end else if (cap && (m_drop < 32767)) begin
            m_drop++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Tick while tracking handshakes; every 4th handshake is a header.
    task automatic tick_log();
        if (trace_valid_o && ready) begin
            if (hs_cnt % 4 == 0) begin
                check_val("seq_field", 32'(trace_data_o[17:15]), 32'(rec_cnt % 8));
                rec_cnt++;
            end
            hs_cnt++;
        end
        tick();
    endtask

    task automatic rand_fields();
        trap  = 1'($urandom);
        intr  = 1'($urandom);
        mode  = 2'($urandom);
        rd    = ($urandom % 8 == 0) ? 5'd0 : 5'($urandom);
        wdata = $urandom;
        pc    = $urandom & 32'hFFFF_FFFC;
        insn  = $urandom;
    endtask

    task automatic set_retire(input logic [31:0] p, input logic [31:0] i,
                              input logic [4:0] r, input logic [31:0] w);
        rv = 1'b1; pc = p; insn = i; rd = r; wdata = w;
        trap = 1'b0; intr = 1'b0; mode = 2'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rv  = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int ready_pct;
        rst = 1'b1; en = 1'b0; rv = 1'b0; ready = 1'b0;
        trap = 1'b0; intr = 1'b0; mode = 2'd0; rd = 5'd0;
        wdata = 32'd0; pc = 32'd0; insn = 32'd0;
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;
        check_val("rst_valid", trace_valid_o, 32'd0);
        check_val("rst_level", level_o, 32'd0);
        check_val("rst_drop", drop_cnt_o, 32'd0);
        check_val("rst_data", trace_data_o, 32'd0);

        // Single retire, ready high.
        ready = 1'b1;
        set_retire(32'h80, 32'h0050_0093, 5'd1, 32'd5);
        check_val("t1_valid_cycN", trace_valid_o, 32'd0);
        tick();
        rv = 1'b0;
        check_val("t1_valid_N1", trace_valid_o, 32'd1);
        check_val("t1_hdr", trace_data_o, 32'hA004_0000);
        check_val("t1_hdr_last", trace_last_o, 32'd0);
        tick();
        check_val("t1_pc", trace_data_o, 32'h0000_0080);
        tick();
        check_val("t1_insn", trace_data_o, 32'h0050_0093);
        tick();
        check_val("t1_wdata", trace_data_o, 32'h0000_0005);
        check_val("t1_last", trace_last_o, 32'd1);
        tick();
        check_val("t1_done", trace_valid_o, 32'd0);

        // Overflow with ready low, then drop reporting.
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            rand_fields();
            rv = 1'b1;
            tick();
        end
        rv = 1'b0;
        check_val("t2_level", level_o, 32'd8);
        check_val("t2_drop", drop_cnt_o, 32'd2);
        ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        ready = 1'b0;
        rand_fields();
        rv = 1'b1;
        tick();
        rv = 1'b0;
        check_val("t2_drop_clr", drop_cnt_o, 32'd0);
        check_val("t2_level_refill", level_o, 32'd8);
        ready = 1'b1;
        for (int i = 0; i < 28; i++) tick();
        check_val("t2_hdr_dropflag", 32'(trace_data_o[27]), 32'd1);
        check_val("t2_hdr_dropcnt", 32'(trace_data_o[14:0]), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        check_val("t2_empty", trace_valid_o, 32'd0);

        // Back-pressure on the INSN word.
        set_retire(32'h0000_1000, 32'h1234_5678, 5'd3, 32'h0000_DEAD);
        tick();
        rv = 1'b0;
        tick();
        tick();
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("t3_insn_hold", trace_data_o, 32'h1234_5678);
            tick();
        end
        ready = 1'b1;
        check_val("t3_insn_rel", trace_data_o, 32'h1234_5678);
        tick();
        check_val("t3_wdata", trace_data_o, 32'h0000_DEAD);
        check_val("t3_last", trace_last_o, 32'd1);
        tick();

        // Full FIFO with a retire landing on the final WDATA handshake.
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rand_fields();
            rv = 1'b1;
            tick();
        end
        rv = 1'b0;
        check_val("t4_full", level_o, 32'd8);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        rand_fields();
        rv = 1'b1;
        tick();
        rv = 1'b0;
        check_val("t4_drop", drop_cnt_o, 32'd0);
        check_val("t4_level", level_o, 32'd8);
        for (int i = 0; i < 40 && trace_valid_o; i++) tick();
        check_val("t4_drained", trace_valid_o, 32'd0);

        // Sequence numbers across 9 accepted retires.
        do_reset();
        hs_cnt  = 0;
        rec_cnt = 0;
        ready   = 1'b1;
        for (int i = 0; i < 9; i++) begin
            rand_fields();
            rv = 1'b1;
            tick_log();
        end
        rv = 1'b0;
        for (int i = 0; i < 60 && trace_valid_o; i++) tick_log();
        check_val("t5_records", 32'(rec_cnt), 32'd9);

        // Reset while on the PC word with 3 records queued.
        ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rand_fields();
            rv = 1'b1;
            tick();
        end
        rv    = 1'b0;
        ready = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t6_valid", trace_valid_o, 32'd0);
        check_val("t6_level", level_o, 32'd0);
        check_val("t6_drop", drop_cnt_o, 32'd0);
        rand_fields();
        rv = 1'b1;
        tick();
        rv = 1'b0;
        check_val("t6_magic", 32'(trace_data_o[31:28]), 32'hA);
        check_val("t6_seq", 32'(trace_data_o[17:15]), 32'd0);
        check_val("t6_hdr_last", trace_last_o, 32'd0);
        for (int i = 0; i < 4; i++) tick();

        // Randomized traffic with varying back-pressure and enable.
        ready_pct = 50;
        for (int c = 0; c < 4000; c++) begin
            if (c % 200 == 0) ready_pct = $urandom_range(5, 100);
            rand_fields();
            en    = ($urandom % 8) != 0;
            rv    = ($urandom % 3) != 0;
            ready = ($urandom_range(0, 99) < ready_pct);
            rst   = ($urandom % 700) == 0;
            tick();
        end
        rst = 1'b0;
        rv  = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 40; i++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
